link_sync_8b10b: RTL and testbench



---
 rtl/link_sync_8b10b.sv | 196 +++++++++++++++++++
 tb/tb_link_sync_8b10b.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/link_sync_8b10b.sv
// Receive-side link synchronizer after the 8b10b decoder: comma acquisition,
// error-count based loss of sync, bit-slip requests and in-sync word forwarding.
module link_sync_8b10b #(
  parameter int unsigned ACQ_COMMAS   = 3,
  parameter int unsigned LOSS_ERRS    = 4,
  parameter int unsigned GOOD_RUN     = 4,
  parameter int unsigned SLIP_TIMEOUT = 64
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             dec_valid,
  input  logic [7:0]                       dec_data,
  input  logic                             dec_is_k,
  input  logic                             dec_code_err,
  input  logic                             dec_disp_err,
  output logic                             slip,
  output logic                             synced,
  output logic                             out_valid,
  output logic [7:0]                       out_data,
  output logic                             out_is_k,
  output logic                             out_err,
  output logic [$clog2(LOSS_ERRS+1)-1:0]   err_cnt
);

  localparam int unsigned CW = $clog2(ACQ_COMMAS + 1);
  localparam int unsigned EW = $clog2(LOSS_ERRS + 1);
  localparam int unsigned GW = $clog2(GOOD_RUN + 2);
  localparam int unsigned TW = $clog2(SLIP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cc_q, cc_d;
  logic [EW-1:0] ec_q, ec_d;
  logic [GW-1:0] gr_q, gr_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          slip_q, slip_d;
  logic          synced_q, synced_d;
  logic          ov_q, ov_d;
  logic [7:0]    od_q, od_d;
  logic          ok_q, ok_d;
  logic          oe_q, oe_d;

  logic          bad;
  logic          comma;
  logic [TW-1:0] tmr_inc;
  logic          tmr_hit;
  logic [CW-1:0] cc_inc;
  logic [EW-1:0] ec_inc;
  logic [GW-1:0] gr_inc;

  assign bad     = dec_code_err | dec_disp_err;
  assign comma   = dec_is_k & (dec_data == 8'hBC) & ~bad;
  assign tmr_inc = tmr_q + TW'(1);
  assign tmr_hit = (tmr_inc == TW'(SLIP_TIMEOUT));
  assign cc_inc  = cc_q + CW'(1);
  assign ec_inc  = ec_q + EW'(1);
  assign gr_inc  = gr_q + GW'(1);

  // Next-state and registered-output computation; everything holds on idle cycles.
  always_comb begin
    state_d  = state_q;
    cc_d     = cc_q;
    ec_d     = ec_q;
    gr_d     = gr_q;
    tmr_d    = tmr_q;
    slip_d   = 1'b0;
    ov_d     = 1'b0;
    od_d     = od_q;
    ok_d     = ok_q;
    oe_d     = oe_q;
    if (dec_valid) begin
      case (state_q)
        LOS: begin
          if (comma) begin
            tmr_d = '0;
            if (cc_inc >= CW'(ACQ_COMMAS)) begin
              state_d = SYNC;
              cc_d    = '0;
              gr_d    = '0;
              ec_d    = '0;
            end else begin
              state_d = ACQ;
              cc_d    = cc_inc;
            end
          end else if (tmr_hit) begin
            slip_d = 1'b1;
            tmr_d  = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        ACQ: begin
          if (bad) begin
            state_d = LOS;
            cc_d    = '0;
            tmr_d   = '0;
          end else if (comma) begin
            tmr_d = '0;
            if (cc_inc == CW'(ACQ_COMMAS)) begin
              state_d = SYNC;
              cc_d    = '0;
              gr_d    = '0;
              ec_d    = '0;
            end else begin
              cc_d = cc_inc;
            end
          end else if (tmr_hit) begin
            slip_d  = 1'b1;
            state_d = LOS;
            cc_d    = '0;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_inc;
          end
        end
        SYNC: begin
          ov_d = 1'b1;
          od_d = dec_data;
          ok_d = dec_is_k;
          oe_d = bad;
          if (bad) begin
            gr_d = '0;
            if (ec_inc == EW'(LOSS_ERRS)) begin
              state_d = LOS;
              ec_d    = '0;
              tmr_d   = '0;
              cc_d    = '0;
            end else begin
              ec_d = ec_inc;
            end
          end else if (gr_inc >= GW'(GOOD_RUN)) begin
            // A completed good run pays back one error; with no errors it just saturates.
            if (ec_q != '0) begin
              ec_d = ec_q - EW'(1);
              gr_d = '0;
            end else begin
              gr_d = GW'(GOOD_RUN);
            end
          end else begin
            gr_d = gr_inc;
          end
        end
        default: begin
          state_d = LOS;
          cc_d    = '0;
          ec_d    = '0;
          gr_d    = '0;
          tmr_d   = '0;
        end
      endcase
    end
    synced_d = (state_d == SYNC);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= LOS;
      cc_q     <= '0;
      ec_q     <= '0;
      gr_q     <= '0;
      tmr_q    <= '0;
      slip_q   <= 1'b0;
      synced_q <= 1'b0;
      ov_q     <= 1'b0;
      od_q     <= '0;
      ok_q     <= 1'b0;
      oe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cc_q     <= cc_d;
      ec_q     <= ec_d;
      gr_q     <= gr_d;
      tmr_q    <= tmr_d;
      slip_q   <= slip_d;
      synced_q <= synced_d;
      ov_q     <= ov_d;
      od_q     <= od_d;
      ok_q     <= ok_d;
      oe_q     <= oe_d;
    end
  end

  assign slip      = slip_q;
  assign synced    = synced_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_is_k  = ok_q;
  assign out_err   = oe_q;
  assign err_cnt   = ec_q;

endmodule

// File: tb/tb_link_sync_8b10b.sv
// Directed bench for link_sync_8b10b: forwarded words go through a scoreboard
// queue, state outputs are compared directly after each sampled word.
module tb_link_sync_8b10b;

  logic       clk;
  logic       n_rst;
  logic       dec_valid;
  logic [7:0] dec_data;
  logic       dec_is_k;
  logic       dec_code_err;
  logic       dec_disp_err;
  logic       slip;
  logic       synced;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_is_k;
  logic       out_err;
  logic [2:0] err_cnt;

  typedef struct packed {
    logic [7:0] d;
    logic       k;
    logic       e;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   slip_cnt = 0;

  link_sync_8b10b dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .dec_valid    (dec_valid),
    .dec_data     (dec_data),
    .dec_is_k     (dec_is_k),
    .dec_code_err (dec_code_err),
    .dec_disp_err (dec_disp_err),
    .slip         (slip),
    .synced       (synced),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_is_k     (out_is_k),
    .out_err      (out_err),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every forwarded word must match the oldest expected entry.
  always @(negedge clk) begin
    if (n_rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e.d));
        chk("out_is_k", 32'(out_is_k), 32'(e.k));
        chk("out_err",  32'(out_err),  32'(e.e));
      end
    end
    if (n_rst && slip) slip_cnt++;
  end

  task automatic word(input logic [7:0] d, input logic k, input logic ce, input logic de,
                      input logic fwd);
    dec_valid    = 1'b1;
    dec_data     = d;
    dec_is_k     = k;
    dec_code_err = ce;
    dec_disp_err = de;
    if (fwd) exp_q.push_back({d, k, ce | de});
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
  endtask

  task automatic comma(input logic fwd);
    word(8'hBC, 1'b1, 1'b0, 1'b0, fwd);
  endtask

  task automatic idle();
    dec_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int s0;
    n_rst        = 1'b0;
    dec_valid    = 1'b0;
    dec_data     = 8'h00;
    dec_is_k     = 1'b0;
    dec_code_err = 1'b0;
    dec_disp_err = 1'b0;
    #12;
    chk("rst_synced",    32'(synced),    32'(0));
    chk("rst_slip",      32'(slip),      32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data",  32'(out_data),  32'(0));
    chk("rst_err_cnt",   32'(err_cnt),   32'(0));
    @(negedge clk);
    n_rst = 1'b1;
    idle();

    // Acquire with three clean commas, then forward a data word.
    comma(1'b0);
    comma(1'b0);
    chk("acq_synced_after2", 32'(synced), 32'(0));
    comma(1'b0);
    chk("acq_synced_after3", 32'(synced), 32'(1));
    word(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fwd_out_valid", 32'(out_valid), 32'(1));

    // Four disparity errors lose sync; the fourth is forwarded with the error flag.
    for (int i = 1; i <= 3; i++) begin
      word(8'h30 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b1);
      chk("loss_err_cnt", 32'(err_cnt), 32'(i));
    end
    word(8'h34, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("loss_synced",  32'(synced),  32'(0));
    chk("loss_err_cnt0", 32'(err_cnt), 32'(0));

    // Slip timeout: one pulse per 64 comma-free words.
    s0 = slip_cnt;
    for (int i = 1; i <= 128; i++) begin
      word(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 63 || i == 65 || i == 127) chk("slip_low", 32'(slip), 32'(0));
      if (i == 64 || i == 128)            chk("slip_high", 32'(slip), 32'(1));
    end
    idle();
    chk("slip_count", 32'(slip_cnt - s0), 32'(2));

    // A bad comma during acquisition restarts the count from zero.
    comma(1'b0);
    comma(1'b0);
    word(8'hBC, 1'b1, 1'b1, 1'b0, 1'b0);
    comma(1'b0);
    comma(1'b0);
    chk("reacq_synced_after2", 32'(synced), 32'(0));
    comma(1'b0);
    chk("reacq_synced_after3", 32'(synced), 32'(1));

    // Error recovery: two errors repaid by two good runs of four.
    word(8'h41, 1'b0, 1'b0, 1'b1, 1'b1);
    word(8'h42, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rec_err_cnt2", 32'(err_cnt), 32'(2));
    for (int i = 1; i <= 12; i++) begin
      word(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 4)  chk("rec_err_cnt1", 32'(err_cnt), 32'(1));
      if (i == 8)  chk("rec_err_cnt0", 32'(err_cnt), 32'(0));
    end
    chk("rec_err_cnt_hold", 32'(err_cnt), 32'(0));
    chk("rec_synced",       32'(synced),  32'(1));

    // Gapped input: out_valid only after valid words.
    for (int i = 0; i < 4; i++) begin
      word(8'hA0 + 8'(i), 1'(i & 1), 1'b0, 1'b0, 1'b1);
      idle();
      chk("gap_out_valid_low", 32'(out_valid), 32'(0));
    end

    // Asynchronous reset while a forwarded word is on the outputs.
    word(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_out_valid", 32'(out_valid), 32'(1));
    chk("pre_rst_out_data",  32'(out_data),  32'(8'hC3));
    #1;
    n_rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'(0));
    chk("async_rst_synced",    32'(synced),    32'(0));
    chk("async_rst_err_cnt",   32'(err_cnt),   32'(0));
    @(negedge clk);
    n_rst = 1'b1;
    comma(1'b0);
    chk("post_rst_synced", 32'(synced), 32'(0));
    word(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_out_valid", 32'(out_valid), 32'(0));
    idle();
    idle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
